traceback_collector: RTL and testbench

//   Consumer end of the score-unit traceback chain. Starts traceback at the end

---
 rtl/traceback_collector_if.sv | 30 +++
 rtl/traceback_collector.sv | 116 +++++++++++
 tb/tb_traceback_collector.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/traceback_collector_if.sv
// Bus bundle between the traceback collector and its environment: start/score-bus
// inputs and the SRAM write port plus status outputs.
interface traceback_collector_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              i_start;
  logic [31:0]       i_data;
  logic              o_outena;
  logic              o_sram_we;
  logic [ADDR_W-1:0] o_sram_addr;
  logic [31:0]       o_sram_wdata;
  logic              o_busy;
  logic              o_done;
  logic              o_err;
  logic [1:0]        o_errcode;
  logic [5:0]        o_len;
  logic [15:0]       o_score;

  modport master (
    output i_start, i_data,
    input  o_outena, o_sram_we, o_sram_addr, o_sram_wdata, o_busy, o_done, o_err,
    input  o_errcode, o_len, o_score
  );

  modport slave (
    input  i_start, i_data,
    output o_outena, o_sram_we, o_sram_addr, o_sram_wdata, o_busy, o_done, o_err,
    output o_errcode, o_len, o_score
  );
endinterface

// File: rtl/traceback_collector.sv
// Traceback chain consumer: walks from the end cell back to (0,0), storing each
// bus word in SRAM and checking that every step is a legal DTW predecessor move.
module traceback_collector #(
  parameter int unsigned TLEN      = 16,
  parameter int unsigned RLEN      = 16,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input logic                  clk,
  input logic                  rst,
  traceback_collector_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StTrace, StDone} state_e;

  localparam logic [4:0] TEnd = 5'(TLEN - 1);
  localparam logic [4:0] REnd = 5'(RLEN - 1);

  state_e      state_q;
  logic [5:0]  n_q;
  logic [4:0]  pt_q, pr_q;

  logic [4:0]  t, r;
  logic [15:0] d;
  logic [5:0]  t6, r6, pt6, pr6;
  logic        start_ok, stuck, step_ok, at_origin;

  always_comb begin
    t         = bus.i_data[28:24];
    r         = bus.i_data[20:16];
    d         = bus.i_data[15:0];
    t6        = {1'b0, t};
    r6        = {1'b0, r};
    pt6       = {1'b0, pt_q};
    pr6       = {1'b0, pr_q};
    start_ok  = (t == TEnd) && (r == REnd);
    stuck     = (t == pt_q) && (r == pr_q);
    // 6-bit compare so a 31 word never aliases to a 0 predecessor
    step_ok   = ((t6 + 6'd1 == pt6) && (r6 + 6'd1 == pr6)) ||
                ((t6 + 6'd1 == pt6) && (r6 == pr6)) ||
                ((t6 == pt6) && (r6 + 6'd1 == pr6));
    at_origin = (t == 5'd0) && (r == 5'd0);
  end

  assign bus.o_outena = (state_q == StTrace) && (n_q == 6'd0);
  assign bus.o_busy   = (state_q == StTrace);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= StIdle;
      n_q              <= 6'd0;
      pt_q             <= 5'd0;
      pr_q             <= 5'd0;
      bus.o_sram_we    <= 1'b0;
      bus.o_sram_addr  <= '0;
      bus.o_sram_wdata <= 32'd0;
      bus.o_done       <= 1'b0;
      bus.o_err        <= 1'b0;
      bus.o_errcode    <= 2'd0;
      bus.o_len        <= 6'd0;
      bus.o_score      <= 16'd0;
    end else begin
      bus.o_sram_we <= 1'b0;
      bus.o_done    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.i_start) begin
            state_q       <= StTrace;
            n_q           <= 6'd0;
            bus.o_len     <= 6'd0;
            bus.o_err     <= 1'b0;
            bus.o_errcode <= 2'd0;
          end
        end
        StTrace: begin
          if ((n_q == 6'd0) && !start_ok) begin
            bus.o_err     <= 1'b1;
            bus.o_errcode <= 2'b01;
            bus.o_done    <= 1'b1;
            state_q       <= StDone;
          end else if ((n_q != 6'd0) && stuck) begin
            bus.o_err     <= 1'b1;
            bus.o_errcode <= 2'b11;
            bus.o_done    <= 1'b1;
            state_q       <= StDone;
          end else if ((n_q != 6'd0) && !step_ok) begin
            bus.o_err     <= 1'b1;
            bus.o_errcode <= 2'b10;
            bus.o_done    <= 1'b1;
            state_q       <= StDone;
          end else begin
            bus.o_sram_we    <= 1'b1;
            bus.o_sram_addr  <= ADDR_W'(BASE_ADDR + 32'(n_q));
            bus.o_sram_wdata <= bus.i_data;
            bus.o_len        <= n_q + 6'd1;
            n_q              <= n_q + 6'd1;
            pt_q             <= t;
            pr_q             <= r;
            if (n_q == 6'd0) bus.o_score <= d;
            if (at_origin) begin
              bus.o_done <= 1'b1;
              state_q    <= StDone;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_traceback_collector.sv
// Directed bench for traceback_collector on a 4x4 array: legal paths, each error
// class, async reset mid-trace and ignored start pulses.
module tb_traceback_collector;
  localparam int unsigned ADDR_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  traceback_collector_if #(.ADDR_W(ADDR_W)) bus ();

  traceback_collector #(
    .TLEN      (4),
    .RLEN      (4),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0]       seq [16];
  int                seq_n;
  logic [ADDR_W-1:0] wr_addr [$];
  logic [31:0]       wr_data [$];
  int                outena_cnt, busy_cnt;
  logic              done_seen, done_we;

  function automatic logic [31:0] mk(input int t, input int r, input int d);
    return {3'b000, 5'(t), 3'b000, 5'(r), 16'(d)};
  endfunction

  always @(negedge clk) begin
    if (bus.o_sram_we) begin
      wr_addr.push_back(bus.o_sram_addr);
      wr_data.push_back(bus.o_sram_wdata);
    end
    if (bus.o_outena) outena_cnt++;
    if (bus.o_busy) busy_cnt++;
    if (bus.o_done) begin
      done_seen = 1'b1;
      done_we   = bus.o_sram_we;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    wr_addr.delete();
    wr_data.delete();
    outena_cnt = 0;
    busy_cnt   = 0;
    done_seen  = 1'b0;
    done_we    = 1'b0;
  endtask

  // Feed seq[0..seq_n-1] one word per trace cycle; optional stray start at pulse_at.
  task automatic run_trace(input int pulse_at);
    clear_mon();
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_data  = 32'd0;
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_data  = seq[0];
    for (int i = 1; i < seq_n; i++) begin
      @(negedge clk);
      bus.i_data  = seq[i];
      bus.i_start = (i == pulse_at);
    end
    for (int k = 0; k < 8 && !done_seen; k++) begin
      @(negedge clk);
      bus.i_start = 1'b0;
      bus.i_data  = 32'd0;
    end
    bus.i_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic check_run(input string tag, input int nwr, input int len, input logic err,
                           input logic [1:0] code, input int busy);
    chk({tag, ".done_seen"}, 32'(done_seen), 32'd1);
    chk({tag, ".nwrites"}, wr_addr.size(), nwr);
    chk({tag, ".len"}, 32'(bus.o_len), len);
    chk({tag, ".err"}, 32'(bus.o_err), 32'(err));
    chk({tag, ".errcode"}, 32'(bus.o_errcode), 32'(code));
    chk({tag, ".busy_cycles"}, busy_cnt, busy);
    chk({tag, ".outena_cycles"}, outena_cnt, 32'd1);
    chk({tag, ".busy_after"}, 32'(bus.o_busy), 32'd0);
    for (int i = 0; i < wr_addr.size() && i < nwr; i++) begin
      chk($sformatf("%s.addr%0d", tag, i), 32'(wr_addr[i]), i);
      chk($sformatf("%s.data%0d", tag, i), wr_data[i], seq[i]);
    end
  endtask

  initial begin
    bus.i_start = 1'b0;
    bus.i_data  = 32'd0;
    clear_mon();
    repeat (2) @(negedge clk);
    chk("rst.busy", 32'(bus.o_busy), 0);
    chk("rst.outena", 32'(bus.o_outena), 0);
    chk("rst.we", 32'(bus.o_sram_we), 0);
    chk("rst.done", 32'(bus.o_done), 0);
    chk("rst.err", 32'(bus.o_err), 0);
    chk("rst.len", 32'(bus.o_len), 0);
    chk("rst.score", 32'(bus.o_score), 0);
    rst = 1'b0;
    @(negedge clk);

    // Diagonal path
    seq_n = 4;
    seq[0] = mk(3, 3, 16'h0040); seq[1] = mk(2, 2, 16'h0030);
    seq[2] = mk(1, 1, 16'h0020); seq[3] = mk(0, 0, 16'h0010);
    run_trace(-1);
    check_run("diag", 4, 4, 1'b0, 2'b00, 4);
    chk("diag.score", 32'(bus.o_score), 32'h0040);
    chk("diag.done_with_write", 32'(done_we), 1);

    // L-shaped path, junk in ignored bus bits must be stored verbatim
    seq_n = 7;
    seq[0] = mk(3, 3, 16'h0077); seq[1] = mk(2, 3, 5) | 32'hE0E0_0000;
    seq[2] = mk(1, 3, 4); seq[3] = mk(0, 3, 3); seq[4] = mk(0, 2, 2);
    seq[5] = mk(0, 1, 1); seq[6] = mk(0, 0, 0);
    run_trace(-1);
    check_run("lpath", 7, 7, 1'b0, 2'b00, 7);
    chk("lpath.score", 32'(bus.o_score), 32'h0077);

    // Illegal jump
    seq_n = 2;
    seq[0] = mk(3, 3, 16'h0099); seq[1] = mk(1, 2, 1);
    run_trace(-1);
    check_run("jump", 1, 1, 1'b1, 2'b10, 2);
    chk("jump.done_no_write", 32'(done_we), 0);

    // Bad first cell
    seq_n = 1;
    seq[0] = mk(2, 3, 1);
    run_trace(-1);
    check_run("badstart", 0, 0, 1'b1, 2'b01, 1);

    // Stuck on same cell
    seq_n = 2;
    seq[0] = mk(3, 3, 8); seq[1] = mk(3, 3, 8);
    run_trace(-1);
    check_run("stuck", 1, 1, 1'b1, 2'b11, 2);

    // Wrap from (0,1) to (31,0) is illegal
    seq_n = 7;
    seq[0] = mk(3, 3, 6); seq[1] = mk(2, 3, 5); seq[2] = mk(1, 3, 4);
    seq[3] = mk(0, 3, 3); seq[4] = mk(0, 2, 2); seq[5] = mk(0, 1, 1);
    seq[6] = mk(31, 0, 0);
    run_trace(-1);
    check_run("wrap", 6, 6, 1'b1, 2'b10, 7);

    // Async reset at step 2
    seq[0] = mk(3, 3, 16'h0055); seq[1] = mk(2, 2, 3); seq[2] = mk(1, 1, 2);
    clear_mon();
    @(negedge clk);
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_data  = seq[0];
    @(negedge clk);
    bus.i_data  = seq[1];
    @(negedge clk);
    bus.i_data  = seq[2];
    #2 rst = 1'b1;
    #1;
    chk("arst.busy", 32'(bus.o_busy), 0);
    chk("arst.outena", 32'(bus.o_outena), 0);
    chk("arst.we", 32'(bus.o_sram_we), 0);
    chk("arst.len", 32'(bus.o_len), 0);
    chk("arst.score", 32'(bus.o_score), 0);
    @(negedge clk);
    clear_mon();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("arst.nwrites_after", wr_addr.size(), 0);
    chk("arst.busy_after", busy_cnt, 0);

    // Full trace after reset, with a stray start mid-trace
    seq_n = 4;
    seq[0] = mk(3, 3, 16'h0123); seq[1] = mk(2, 2, 3);
    seq[2] = mk(1, 1, 2); seq[3] = mk(0, 0, 1);
    run_trace(1);
    check_run("restart", 4, 4, 1'b0, 2'b00, 4);
    chk("restart.score", 32'(bus.o_score), 32'h0123);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
